// File: rtl/shift_sched_if.sv
// Request/response bundle for shift_sched: two requester channels and one
// tagged response channel, all valid/ready.
interface shift_sched_if #(
    parameter int XLEN = 64,
    parameter int AMTW = 6,
    parameter int TAGW = 4
);
    logic            req0_valid;
    logic            req0_ready;
    logic [1:0]      req0_op;
    logic [XLEN-1:0] req0_data;
    logic [AMTW-1:0] req0_amt;
    logic [TAGW-1:0] req0_tag;

    logic            req1_valid;
    logic            req1_ready;
    logic [1:0]      req1_op;
    logic [XLEN-1:0] req1_data;
    logic [AMTW-1:0] req1_amt;
    logic [TAGW-1:0] req1_tag;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_src;
    logic [TAGW-1:0] resp_tag;

    modport master (
        output req0_valid, req0_op, req0_data, req0_amt, req0_tag,
        output req1_valid, req1_op, req1_data, req1_amt, req1_tag,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_src, resp_tag
    );

    modport slave (
        input  req0_valid, req0_op, req0_data, req0_amt, req0_tag,
        input  req1_valid, req1_op, req1_data, req1_amt, req1_tag,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_src, resp_tag
    );
endinterface

// File: rtl/shift_sched.sv
// Round-robin sequencer sharing one external right shifter between two
// requesters; builds SLL by bit reversal and ROR from two shifter passes.
module shift_sched #(
    parameter int XLEN = 64,
    parameter int AMTW = 6,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_sched_if.slave    bus,
    output logic [XLEN-1:0] sh_in,
    output logic [AMTW-1:0] sh_amt,
    output logic            sh_control,
    input  logic [XLEN-1:0] sh_out,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXEC, PASS2, RESP} state_t;
    typedef enum logic [1:0] {OP_SRL, OP_SRA, OP_SLL, OP_ROR} op_t;

    state_t          state, next_state;
    logic            rr_ptr;
    logic            gnt0, gnt1, grant;
    op_t             lat_op;
    logic [XLEN-1:0] lat_data;
    logic [AMTW-1:0] lat_amt;
    logic [TAGW-1:0] lat_tag;
    logic            lat_src;
    logic [XLEN-1:0] partial;
    logic            load_resp;
    logic [XLEN-1:0] resp_next;

    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
        return r;
    endfunction

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        load_resp  = 1'b0;
        resp_next  = sh_out;
        unique case (state)
            IDLE: begin
                if (rst_n) begin
                    gnt0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
                    gnt1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
                end
                if (gnt0 || gnt1) next_state = EXEC;
            end
            EXEC: begin
                if (lat_op == OP_ROR && lat_amt != '0) begin
                    next_state = PASS2;
                end else begin
                    next_state = RESP;
                    load_resp  = 1'b1;
                    resp_next  = (lat_op == OP_SLL) ? bitrev(sh_out) : sh_out;
                end
            end
            PASS2: begin
                next_state = RESP;
                load_resp  = 1'b1;
                resp_next  = partial | bitrev(sh_out);
            end
            RESP: if (bus.resp_ready) next_state = IDLE;
        endcase
    end

    // Shifter is idle-driven to zero outside the two execute states.
    always_comb begin
        sh_in      = '0;
        sh_amt     = '0;
        sh_control = 1'b0;
        if (state == EXEC) begin
            sh_in      = (lat_op == OP_SLL) ? bitrev(lat_data) : lat_data;
            sh_amt     = lat_amt;
            sh_control = (lat_op == OP_SRA);
        end else if (state == PASS2) begin
            sh_in  = bitrev(lat_data);
            sh_amt = AMTW'(XLEN) - lat_amt;
        end
    end

    assign grant          = gnt0 || gnt1;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.resp_valid = (state == RESP);
    assign busy           = rst_n && (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr        <= 1'b0;
            bus.resp_data <= '0;
            bus.resp_src  <= 1'b0;
            bus.resp_tag  <= '0;
        end else begin
            if (grant) rr_ptr <= gnt0;
            if (load_resp) begin
                bus.resp_data <= resp_next;
                bus.resp_src  <= lat_src;
                bus.resp_tag  <= lat_tag;
            end
        end
    end

    // NOTE: payload registers are not reset; they are only read after a grant loads them.
    always_ff @(posedge clk) begin
        if (grant) begin
            lat_src  <= gnt1;
            lat_op   <= op_t'(gnt1 ? bus.req1_op : bus.req0_op);
            lat_data <= gnt1 ? bus.req1_data : bus.req0_data;
            lat_amt  <= gnt1 ? bus.req1_amt  : bus.req0_amt;
            lat_tag  <= gnt1 ? bus.req1_tag  : bus.req0_tag;
        end
        if (state == EXEC) partial <= sh_out;
    end

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: directed table, random ops against an arithmetic
// reference, stall, reset-in-flight and round-robin sequences.
module tb_shift_sched;
    localparam int XLEN = 64;
    localparam int AMTW = 6;
    localparam int TAGW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_sched_if #(.XLEN(XLEN), .AMTW(AMTW), .TAGW(TAGW)) bus ();

    logic [XLEN-1:0]        sh_in, sh_out, sh_srl, sh_sra;
    logic signed [XLEN-1:0] sh_in_s;
    logic [AMTW-1:0]        sh_amt;
    logic                   sh_control, busy;

    // Stand-in for the external combinational right shifter.
    assign sh_in_s = sh_in;
    assign sh_sra  = sh_in_s >>> sh_amt;
    assign sh_srl  = sh_in >> sh_amt;
    assign sh_out  = sh_control ? sh_sra : sh_srl;

    shift_sched #(.XLEN(XLEN), .AMTW(AMTW), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sh_in      (sh_in),
        .sh_amt     (sh_amt),
        .sh_control (sh_control),
        .sh_out     (sh_out),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] x, input int a);
        logic signed [63:0] sx;
        logic [127:0]       w;
        case (op)
            2'd0: return x >> a;
            2'd1: begin sx = x; sx = sx >>> a; return sx; end
            2'd2: return x << a;
            default: begin w = {x, x} >> a; return w[63:0]; end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input int a);
        return (op == 2'd3 && a != 0) ? 3 : 2;
    endfunction

    function automatic logic rdy(input logic src);
        return src ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic set_req(input logic src, input logic v, input logic [1:0] op,
                           input logic [63:0] data, input logic [5:0] amt, input logic [3:0] tag);
        if (src) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_data = data;
            bus.req1_amt = amt; bus.req1_tag = tag;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_data = data;
            bus.req0_amt = amt; bus.req0_tag = tag;
        end
    endtask

    // Entered and left at a falling edge; cycle T is the cycle ready is seen.
    task automatic run_op(input logic src, input logic [1:0] op, input logic [63:0] data,
                          input logic [5:0] amt, input logic [3:0] tag,
                          output logic [63:0] d, output logic rs, output logic [3:0] rt,
                          output int lat);
        int n;
        set_req(src, 1'b1, op, data, amt, tag);
        #1;
        n = 0;
        while (!rdy(src) && n < 10) begin @(negedge clk); #1; n++; end
        if (!rdy(src)) begin
            total++; bad++;
            $display("FAIL accept_timeout: got=no_ready expected=ready");
        end
        @(negedge clk);
        set_req(src, 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        #1;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin @(negedge clk); #1; lat++; end
        d  = bus.resp_data;
        rs = bus.resp_src;
        rt = bus.resp_tag;
        @(negedge clk);
    endtask

    task automatic op_check(input string nm, input logic src, input logic [1:0] op,
                            input logic [63:0] data, input logic [5:0] amt, input logic [3:0] tag,
                            input logic [63:0] exp, input int exp_lat);
        logic [63:0] d;
        logic        rs;
        logic [3:0]  rt;
        int          lat;
        run_op(src, op, data, amt, tag, d, rs, rt, lat);
        check({nm, "_data"}, d, exp);
        check({nm, "_src"}, 64'(rs), 64'(src));
        check({nm, "_tag"}, 64'(rt), 64'(tag));
        check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    typedef struct {
        logic        src;
        logic [1:0]  op;
        logic [63:0] data;
        logic [5:0]  amt;
        logic [3:0]  tag;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [63:0] d0, x;
        logic [1:0]  op;
        logic [5:0]  amt;
        logic        src, s0;
        logic [3:0]  t0;
        int          n, cnt;

        vecs[0] = '{1'b0, 2'd0, 64'h8000000000000000, 6'd63, 4'h5, 64'h0000000000000001, 2};
        vecs[1] = '{1'b1, 2'd1, 64'h8000000000000000, 6'd4,  4'h6, 64'hF800000000000000, 2};
        vecs[2] = '{1'b1, 2'd1, 64'hFFFFFFFFFFFFFFFF, 6'd1,  4'h7, 64'hFFFFFFFFFFFFFFFF, 2};
        vecs[3] = '{1'b0, 2'd2, 64'h0000000000000001, 6'd63, 4'h8, 64'h8000000000000000, 2};
        vecs[4] = '{1'b1, 2'd2, 64'h00000000000000F0, 6'd4,  4'h9, 64'h0000000000000F00, 2};
        vecs[5] = '{1'b0, 2'd3, 64'h123456789ABCDEF0, 6'd4,  4'hA, 64'h0123456789ABCDEF, 3};
        vecs[6] = '{1'b1, 2'd3, 64'h123456789ABCDEF0, 6'd0,  4'hB, 64'h123456789ABCDEF0, 2};
        vecs[7] = '{1'b0, 2'd1, 64'h7FFFFFFFFFFFFFFF, 6'd63, 4'hC, 64'h0000000000000000, 2};
        vecs[8] = '{1'b1, 2'd3, 64'h0000000000000001, 6'd1,  4'hD, 64'h8000000000000000, 3};
        vecs[9] = '{1'b0, 2'd3, 64'h8000000000000001, 6'd63, 4'hE, 64'h0000000000000003, 3};

        // Reset: readies held off even with a valid request present.
        rst_n = 1'b0;
        set_req(1'b0, 1'b1, 2'd0, 64'd0, 6'd0, 4'd0);
        set_req(1'b1, 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", bus.resp_data, 64'd0);
        check("rst_resp_src_tag", {59'd0, bus.resp_src, bus.resp_tag}, 64'd0);
        set_req(1'b0, 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            op_check($sformatf("vec%0d", i), vecs[i].src, vecs[i].op, vecs[i].data,
                     vecs[i].amt, vecs[i].tag, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            src = 1'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            x   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       amt = 6'd0;
                1:       amt = 6'd63;
                default: amt = 6'($urandom_range(0, 63));
            endcase
            op_check($sformatf("rnd%0d", i), src, op, x, amt, 4'($urandom_range(0, 15)),
                     model(op, x, int'(amt)), model_lat(op, int'(amt)));
        end

        // Stall in RESP with another request pending.
        bus.resp_ready = 1'b0;
        set_req(1'b1, 1'b1, 2'd0, 64'hDEADBEEF00000000, 6'd16, 4'd3);
        #1;
        check("stall_accept", 64'(bus.req1_ready), 64'd1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        set_req(1'b0, 1'b1, 2'd0, 64'h55, 6'd0, 4'd4);
        #1;
        n = 0;
        while (!bus.resp_valid && n < 10) begin @(negedge clk); #1; n++; end
        check("stall_data", bus.resp_data, 64'h0000DEADBEEF0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", 64'(bus.resp_valid), 64'd1);
            check("stall_hold", bus.resp_data, 64'h0000DEADBEEF0000);
            check("stall_src_tag", {59'd0, bus.resp_src, bus.resp_tag}, {59'd0, 1'b1, 4'd3});
            check("stall_readies", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("after_stall_accept", 64'(bus.req0_ready), 64'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        #1;
        n = 0;
        while (!bus.resp_valid && n < 10) begin @(negedge clk); #1; n++; end
        check("after_stall_resp", {bus.resp_data[58:0], bus.resp_src, bus.resp_tag},
              {59'h55, 1'b0, 4'd4});
        @(negedge clk);

        // Reset while a ROR sits in its second pass.
        set_req(1'b0, 1'b1, 2'd3, 64'hA5A5A5A5F0F0F0F0, 6'd8, 4'd2);
        #1;
        check("rp_accept", 64'(bus.req0_ready), 64'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        #1;
        check("rp_busy_exec", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(1'b1, 1'b1, 2'd0, 64'h1, 6'd0, 4'd1);
        #1;
        check("rp_busy_in_rst", 64'(busy), 64'd0);
        check("rp_ready_in_rst", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        #1;
        check("rp_valid_after", 64'(bus.resp_valid), 64'd0);
        check("rp_busy_after", 64'(busy), 64'd0);
        check("rp_data_after", bus.resp_data, 64'd0);
        set_req(1'b1, 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (bus.resp_valid) cnt++;
        end
        check("rp_no_resp", 64'(cnt), 64'd0);
        @(negedge clk);

        // Both requesters continuously valid, four ops each.
        begin
            int i_r[2];
            int ng, nr, two, viol;
            logic        g_src[8];
            logic        r_src[8];
            logic [3:0]  r_tag[8];
            logic [63:0] r_dat[8];
            logic [63:0] e_dat[8];
            logic        r0, r1;
            i_r[0] = 0; i_r[1] = 0;
            ng = 0; nr = 0; two = 0; viol = 0;
            for (int c = 0; c < 100 && nr < 8; c++) begin
                for (int r = 0; r < 2; r++)
                    set_req(1'(r), i_r[r] < 4, 2'(i_r[r]),
                            64'hF0E1D2C3B4A59687 ^ {r[7:0], 8'(i_r[r]), 48'hC0FFEE},
                            6'(i_r[r] * 7 + r * 3 + 1), 4'(i_r[r] + 1));
                #1;
                r0 = bus.req0_ready;
                r1 = bus.req1_ready;
                if (r0 && r1) two++;
                if ((r0 || r1) && busy) viol++;
                if ((r0 || r1) && ng < 8) begin
                    g_src[ng] = r1;
                    e_dat[ng] = model(r1 ? bus.req1_op : bus.req0_op,
                                      r1 ? bus.req1_data : bus.req0_data,
                                      int'(r1 ? bus.req1_amt : bus.req0_amt));
                    ng++;
                    if (r1) i_r[1]++; else i_r[0]++;
                end
                if (bus.resp_valid && nr < 8) begin
                    r_src[nr] = bus.resp_src;
                    r_tag[nr] = bus.resp_tag;
                    r_dat[nr] = bus.resp_data;
                    nr++;
                end
                @(negedge clk);
            end
            check("rr_grants", 64'(ng), 64'd8);
            check("rr_resps", 64'(nr), 64'd8);
            check("rr_two_ready", 64'(two), 64'd0);
            check("rr_ready_busy", 64'(viol), 64'd0);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("rr_grant%0d", k), 64'(g_src[k]), 64'(k % 2));
                check($sformatf("rr_src%0d", k), 64'(r_src[k]), 64'(k % 2));
                check($sformatf("rr_tag%0d", k), 64'(r_tag[k]), 64'(k / 2 + 1));
                check($sformatf("rr_data%0d", k), r_dat[k], e_dat[k]);
            end
            for (int r = 0; r < 2; r++) set_req(1'(r), 1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
        end

        d0 = 64'd0; s0 = 1'b0; t0 = 4'd0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
